// File: rtl/z80_irq_ctrl.sv
// rtl/z80_irq_ctrl.sv - Z80 interrupt-state controller (IFF1/IFF2, IM, EI delay, NMI latch, maskable priority)
//
// Ports:
//   clk, reset_n      core clock, synchronous active-low reset
//   insn_done         last-cycle pulse of each instruction; qualifies cmd_* / im_mode
//   cmd_ei/di/retn/im completing-instruction decode from the sequencer
//   im_mode           n for IM n (3 is ignored)
//   nmi_n             synchronised NMI pin, falling-edge active
//   irq, irq_mask     maskable request levels and per-line blocks (1 = blocked)
//   int_ack           sequencer begins acceptance of the presented request
//   iff1, iff2, im    architectural interrupt state
//   ei_pending        EI acceptance-delay window is open
//   int_req, int_nmi  registered request to the sequencer and its kind
//   int_src           winning maskable line (index 0 highest priority)
//   int_vector        IM2 vector low byte for int_src

module z80_irq_ctrl #(
    parameter int          NUM_IRQ  = 4,
    parameter int          EI_DELAY = 1,
    parameter logic [7:0]  VEC_BASE = 8'h00,
    localparam int         SRC_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               insn_done,
    input  logic               cmd_ei,
    input  logic               cmd_di,
    input  logic               cmd_retn,
    input  logic               cmd_im,
    input  logic [1:0]         im_mode,
    input  logic               nmi_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               int_ack,
    output logic               iff1,
    output logic               iff2,
    output logic [1:0]         im,
    output logic               ei_pending,
    output logic               int_req,
    output logic               int_nmi,
    output logic [SRC_W-1:0]   int_src,
    output logic [7:0]         int_vector
);

    logic [1:0]         ei_cnt;
    logic               nmi_pend;
    logic               nmi_prev;

    logic [NUM_IRQ-1:0] eligible;
    logic [SRC_W-1:0]   win_idx;
    logic [7:0]         win_vec;
    logic               nmi_edge;
    logic               ack_ok;

    assign eligible   = irq & ~irq_mask;
    assign nmi_edge   = nmi_prev & ~nmi_n;
    // An ack only means something while a request is being presented.
    assign ack_ok     = int_ack & int_req;
    assign ei_pending = (ei_cnt != 2'd0);

    // Lowest set index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = SRC_W'(i);
            end
        end
    end

    // Vector wraps modulo 256 by plain 8-bit truncation.
    assign win_vec = VEC_BASE + ({{(8 - SRC_W){1'b0}}, win_idx} << 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            iff1       <= 1'b0;
            iff2       <= 1'b0;
            im         <= 2'd0;
            ei_cnt     <= 2'd0;
            nmi_pend   <= 1'b0;
            nmi_prev   <= 1'b1;
            int_req    <= 1'b0;
            int_nmi    <= 1'b0;
            int_src    <= '0;
            int_vector <= VEC_BASE;
        end else begin
            nmi_prev <= nmi_n;

            // A fresh edge coinciding with the NMI ack keeps the latch set.
            if (ack_ok && int_nmi) begin
                nmi_pend <= nmi_edge;
            end else if (nmi_edge) begin
                nmi_pend <= 1'b1;
            end

            // Request drops on the ack edge so the sequencer never sees a stale repeat.
            if (ack_ok) begin
                int_req <= 1'b0;
                int_nmi <= 1'b0;
            end else if (nmi_pend) begin
                int_req <= 1'b1;
                int_nmi <= 1'b1;
            end else if (iff1 && (ei_cnt == 2'd0) && (|eligible)) begin
                int_req    <= 1'b1;
                int_nmi    <= 1'b0;
                int_src    <= win_idx;
                int_vector <= win_vec;
            end else begin
                int_req <= 1'b0;
                int_nmi <= 1'b0;
            end

            // Acceptance owns the IFFs when it collides with a command.
            if (ack_ok) begin
                if (int_nmi) begin
                    iff2 <= iff1;
                    iff1 <= 1'b0;
                end else begin
                    iff1 <= 1'b0;
                    iff2 <= 1'b0;
                end
            end else if (insn_done) begin
                if (cmd_di) begin
                    iff1 <= 1'b0;
                    iff2 <= 1'b0;
                end else if (cmd_ei) begin
                    iff1 <= 1'b1;
                    iff2 <= 1'b1;
                end else if (cmd_retn) begin
                    iff1 <= iff2;
                end
            end

            if (insn_done) begin
                if (cmd_di) begin
                    ei_cnt <= 2'd0;
                end else if (cmd_ei) begin
                    ei_cnt <= 2'(EI_DELAY);
                end else if (ei_cnt != 2'd0) begin
                    ei_cnt <= ei_cnt - 2'd1;
                end
                if (cmd_im && (im_mode != 2'd3)) begin
                    im <= im_mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_z80_irq_ctrl.sv
// tb/tb_z80_irq_ctrl.sv - self-checking bench for z80_irq_ctrl with a behavioural reference model

module tb_z80_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       insn_done = 1'b0;
    logic       cmd_ei = 1'b0;
    logic       cmd_di = 1'b0;
    logic       cmd_retn = 1'b0;
    logic       cmd_im = 1'b0;
    logic [1:0] im_mode = 2'd0;
    logic       nmi_n = 1'b1;
    logic [3:0] irq = 4'h0;
    logic [3:0] irq_mask = 4'h0;
    logic       int_ack = 1'b0;

    logic       d0_iff1, d0_iff2, d0_eip, d0_req, d0_nmi;
    logic [1:0] d0_im, d0_src;
    logic [7:0] d0_vec;
    logic       d1_iff1, d1_iff2, d1_eip, d1_req, d1_nmi;
    logic [1:0] d1_im, d1_src;
    logic [7:0] d1_vec;

    always #5 clk = ~clk;

    z80_irq_ctrl #(.NUM_IRQ(4), .EI_DELAY(1), .VEC_BASE(8'h00)) dut0 (
        .clk(clk), .reset_n(reset_n), .insn_done(insn_done),
        .cmd_ei(cmd_ei), .cmd_di(cmd_di), .cmd_retn(cmd_retn), .cmd_im(cmd_im),
        .im_mode(im_mode), .nmi_n(nmi_n), .irq(irq), .irq_mask(irq_mask),
        .int_ack(int_ack), .iff1(d0_iff1), .iff2(d0_iff2), .im(d0_im),
        .ei_pending(d0_eip), .int_req(d0_req), .int_nmi(d0_nmi),
        .int_src(d0_src), .int_vector(d0_vec)
    );

    z80_irq_ctrl #(.NUM_IRQ(4), .EI_DELAY(3), .VEC_BASE(8'hFE)) dut1 (
        .clk(clk), .reset_n(reset_n), .insn_done(insn_done),
        .cmd_ei(cmd_ei), .cmd_di(cmd_di), .cmd_retn(cmd_retn), .cmd_im(cmd_im),
        .im_mode(im_mode), .nmi_n(nmi_n), .irq(irq), .irq_mask(irq_mask),
        .int_ack(int_ack), .iff1(d1_iff1), .iff2(d1_iff2), .im(d1_im),
        .ei_pending(d1_eip), .int_req(d1_req), .int_nmi(d1_nmi),
        .int_src(d1_src), .int_vector(d1_vec)
    );

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    // Reference state, one slot per instance.
    bit m_iff1[2], m_iff2[2], m_pend[2], m_prev[2], m_req[2], m_nmi[2];
    int m_im[2], m_cnt[2], m_src[2], m_vec[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    // One clock edge of architectural behaviour, from the rules rather than any encoding.
    task automatic model_step(input int k);
        int  eid, vb, elig, best;
        bit  ack, edge_seen;
        eid = (k == 0) ? 1 : 3;
        vb  = (k == 0) ? 0 : 254;
        if (!reset_n) begin
            m_iff1[k] = 0; m_iff2[k] = 0; m_im[k] = 0; m_cnt[k] = 0;
            m_pend[k] = 0; m_prev[k] = 1; m_req[k] = 0; m_nmi[k] = 0;
            m_src[k] = 0; m_vec[k] = vb;
            return;
        end
        elig = int'(irq & ~irq_mask);
        ack = int_ack && m_req[k];
        edge_seen = m_prev[k] && !nmi_n;
        best = -1;
        for (int i = 0; i < 4; i++) if (best < 0 && elig[i]) best = i;
        begin
            bit was_nmi = m_nmi[k];
            bit old_pend = m_pend[k];
            bit old_iff1 = m_iff1[k];
            bit old_iff2 = m_iff2[k];
            int old_cnt = m_cnt[k];
            if (ack) begin
                m_req[k] = 0; m_nmi[k] = 0;
            end else if (old_pend) begin
                m_req[k] = 1; m_nmi[k] = 1;
            end else if (old_iff1 && old_cnt == 0 && best >= 0) begin
                m_req[k] = 1; m_nmi[k] = 0;
                m_src[k] = best; m_vec[k] = (vb + 2 * best) % 256;
            end else begin
                m_req[k] = 0; m_nmi[k] = 0;
            end
            m_pend[k] = (ack && was_nmi) ? edge_seen : (old_pend || edge_seen);
            if (ack) begin
                m_iff1[k] = 0;
                m_iff2[k] = was_nmi ? old_iff1 : 0;
            end else if (insn_done) begin
                if (cmd_di) begin m_iff1[k] = 0; m_iff2[k] = 0; end
                else if (cmd_ei) begin m_iff1[k] = 1; m_iff2[k] = 1; end
                else if (cmd_retn) m_iff1[k] = old_iff2;
            end
            if (insn_done) begin
                if (cmd_di) m_cnt[k] = 0;
                else if (cmd_ei) m_cnt[k] = eid;
                else if (old_cnt > 0) m_cnt[k] = old_cnt - 1;
                if (cmd_im && im_mode != 2'd3) m_im[k] = int'(im_mode);
            end
            m_prev[k] = nmi_n;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic cmp(input int k, input logic f1, input logic f2, input logic [1:0] im_v,
                       input logic eip, input logic req, input logic nmi,
                       input logic [1:0] src, input logic [7:0] vec);
        string p;
        p = (k == 0) ? "d0" : "d1";
        chk({p, ".iff1"}, 32'(f1), 32'(m_iff1[k]));
        chk({p, ".iff2"}, 32'(f2), 32'(m_iff2[k]));
        chk({p, ".im"}, 32'(im_v), 32'(m_im[k]));
        chk({p, ".ei_pending"}, 32'(eip), 32'(m_cnt[k] != 0));
        chk({p, ".int_req"}, 32'(req), 32'(m_req[k]));
        chk({p, ".int_nmi"}, 32'(nmi), 32'(m_nmi[k]));
        chk({p, ".int_src"}, 32'(src), 32'(m_src[k]));
        chk({p, ".int_vector"}, 32'(vec), 32'(m_vec[k]));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                cmp(0, d0_iff1, d0_iff2, d0_im, d0_eip, d0_req, d0_nmi, d0_src, d0_vec);
                cmp(1, d1_iff1, d1_iff2, d1_im, d1_eip, d1_req, d1_nmi, d1_src, d1_vec);
            end
        end
    end

    task automatic pulse_insn(input bit ei, input bit di, input bit retn);
        insn_done = 1; cmd_ei = ei; cmd_di = di; cmd_retn = retn;
        tick();
        insn_done = 0; cmd_ei = 0; cmd_di = 0; cmd_retn = 0;
    endtask

    initial begin
        // Reset with hostile inputs.
        reset_n = 0; nmi_n = 0; irq = 4'hF; irq_mask = 4'h0;
        tick(); tick();
        chk_en = 1;
        #3;
        chk("rst.iff1", 32'(d0_iff1), 0);
        chk("rst.im", 32'(d0_im), 0);
        chk("rst.int_req", 32'(d0_req), 0);
        chk("rst.vec0", 32'(d0_vec), 32'h00);
        chk("rst.vec1", 32'(d1_vec), 32'hFE);
        nmi_n = 1;
        tick();
        reset_n = 1;
        tick(); tick();
        #3;
        chk("post_rst.int_req", 32'(d0_req), 0);

        // EI with delay 1, line 2 requesting.
        irq = 4'b0100;
        pulse_insn(1, 0, 0);
        #3;
        chk("ei.iff1", 32'(d0_iff1), 1);
        chk("ei.pending", 32'(d0_eip), 1);
        tick();
        #3;
        chk("ei.blocked", 32'(d0_req), 0);
        pulse_insn(0, 0, 0);
        #3;
        chk("ei.win_closed", 32'(d0_eip), 0);
        chk("ei.req_lag", 32'(d0_req), 0);
        tick();
        #3;
        chk("ei.req", 32'(d0_req), 1);
        chk("ei.src", 32'(d0_src), 2);
        chk("ei.vec", 32'(d0_vec), 32'h04);
        chk("ei.d1_blocked", 32'(d1_req), 0);
        int_ack = 1;
        tick();
        int_ack = 0;
        #3;
        chk("ack.req", 32'(d0_req), 0);
        chk("ack.iff1", 32'(d0_iff1), 0);

        // EI string keeps acceptance blocked.
        irq = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            pulse_insn(1, 0, 0);
            #3;
            chk("eistr.pending", 32'(d0_eip), 1);
            tick();
            #3;
            chk("eistr.req", 32'(d0_req), 0);
        end
        pulse_insn(0, 0, 0);
        #3;
        chk("eistr.lag", 32'(d0_req), 0);
        tick();
        #3;
        chk("eistr.req_up", 32'(d0_req), 1);
        chk("eistr.src", 32'(d0_src), 0);

        // DI colliding with a maskable ack.
        int_ack = 1;
        pulse_insn(0, 1, 0);
        int_ack = 0;
        #3;
        chk("diack.iff1", 32'(d0_iff1), 0);
        chk("diack.iff2", 32'(d0_iff2), 0);
        chk("diack.req", 32'(d0_req), 0);

        // NMI accept then RETN.
        irq = 4'h0;
        pulse_insn(1, 0, 0);
        for (int i = 0; i < 3; i++) pulse_insn(0, 0, 0);
        nmi_n = 0;
        tick(); tick();
        #3;
        chk("nmi.req", 32'(d0_req), 1);
        chk("nmi.kind", 32'(d0_nmi), 1);
        int_ack = 1;
        tick();
        int_ack = 0;
        nmi_n = 1;
        #3;
        chk("nmi.iff1", 32'(d0_iff1), 0);
        chk("nmi.iff2", 32'(d0_iff2), 1);
        chk("nmi.req_drop", 32'(d0_req), 0);
        pulse_insn(0, 0, 1);
        #3;
        chk("retn.iff1", 32'(d0_iff1), 1);

        // Masking and vector wrap.
        irq = 4'b1010; irq_mask = 4'b0010;
        tick(); tick();
        #3;
        chk("mask.src", 32'(d0_src), 3);
        chk("mask.vec0", 32'(d0_vec), 32'h06);
        chk("mask.vec1_wrap", 32'(d1_vec), 32'h04);
        irq = 4'h0; irq_mask = 4'h0;
        pulse_insn(0, 1, 0);

        // IM 2 then the ignored IM 3.
        cmd_im = 1; im_mode = 2'd2;
        pulse_insn(0, 0, 0);
        #3;
        chk("im2", 32'(d0_im), 2);
        im_mode = 2'd3;
        pulse_insn(0, 0, 0);
        cmd_im = 0;
        #3;
        chk("im3_ignored", 32'(d0_im), 2);

        // Random traffic; the compare process checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            reset_n   = ($urandom_range(0, 199) != 0);
            insn_done = ($urandom_range(0, 9) < 3);
            cmd_ei    = ($urandom_range(0, 5) == 0);
            cmd_di    = ($urandom_range(0, 7) == 0);
            cmd_retn  = ($urandom_range(0, 7) == 0);
            cmd_im    = ($urandom_range(0, 5) == 0);
            im_mode   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) nmi_n = ~nmi_n;
            irq       = 4'($urandom_range(0, 15));
            irq_mask  = 4'($urandom_range(0, 15));
            int_ack   = ($urandom_range(0, 4) == 0);
            tick();
        end
        reset_n = 1; insn_done = 0; int_ack = 0;
        cmd_ei = 0; cmd_di = 0; cmd_retn = 0; cmd_im = 0;
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
